// File: rtl/retire_stage_pkg.sv
// Shared back-end types for the retire stage: ROB and commit packets,
// retire FSM states and the kinds of entry that can close a retire group.
package retire_stage_pkg;

    localparam int N                = 4;
    localparam int PHYS_REG_SZ_R10K = 64;
    localparam int ARCH_REG_SZ      = 32;
    localparam int XLEN             = 32;

    typedef logic [$clog2(PHYS_REG_SZ_R10K)-1:0] PHYS_REG_IDX;
    typedef logic [$clog2(ARCH_REG_SZ)-1:0]      REG_IDX;
    typedef logic [XLEN-1:0]                     ADDR;
    typedef logic [XLEN-1:0]                     DATA;

    typedef struct packed {
        PHYS_REG_IDX T_new;
        PHYS_REG_IDX T_old;
        REG_IDX      arch_reg;
        logic        has_dest;
        logic        is_store;
        logic        halt;
        logic        illegal;
        logic        mispredict;
        ADDR         target_pc;
        ADDR         NPC;
    } ROB_PACKET;

    typedef struct packed {
        DATA    data;
        REG_IDX reg_idx;
        ADDR    NPC;
        logic   halt;
        logic   illegal;
        logic   valid;
    } COMMIT_PACKET;

    // Only the fields the prefix scan looks at.
    typedef struct packed {
        PHYS_REG_IDX T_new;
        logic        is_store;
        logic        ends_halt;
        logic        ends_flush;
    } SCAN_ENTRY;

    typedef enum logic [1:0] {RUN, FLUSH, HALTED} RETIRE_STATE;

    typedef enum logic [1:0] {TERM_NONE, TERM_HALT, TERM_MISPREDICT} TERM_KIND;

endpackage

// File: rtl/retire_select.sv
// Combinational prefix scan: picks the longest completed, credit-legal prefix
// of the ROB head and reports which entry (if any) closed the group.
module retire_select
    import retire_stage_pkg::*;
#(
    parameter int  RETIRE_WIDTH = N,
    parameter int  PHYS_REGS    = PHYS_REG_SZ_R10K,
    parameter int  STORE_PORTS  = 1,
    localparam int CW           = $clog2(RETIRE_WIDTH + 1),
    localparam int IW           = (RETIRE_WIDTH > 1) ? $clog2(RETIRE_WIDTH) : 1
) (
    input  logic                          enable_i,
    input  SCAN_ENTRY [RETIRE_WIDTH-1:0]  scan_i,
    input  logic [CW-1:0]                 rob_valid_i,
    input  logic [PHYS_REGS-1:0]          complete_list_i,
    input  logic [CW-1:0]                 sq_store_credit_i,
    output logic [RETIRE_WIDTH-1:0]       retire_mask_o,
    output logic [CW-1:0]                 num_retiring_o,
    output logic [CW-1:0]                 num_store_retiring_o,
    output TERM_KIND                      term_kind_o,
    output logic [IW-1:0]                 term_idx_o
);

    always_comb begin
        int   n_ret;
        int   n_st;
        int   store_cap;
        logic scan_open;

        // NOTE: every output and temporary gets a default before the scan, so no path infers a latch.
        retire_mask_o = '0;
        term_kind_o   = TERM_NONE;
        term_idx_o    = '0;
        n_ret         = 0;
        n_st          = 0;
        store_cap     = (int'(sq_store_credit_i) < STORE_PORTS) ? int'(sq_store_credit_i) : STORE_PORTS;
        scan_open     = enable_i;

        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            if (scan_open) begin
                if (i < int'(rob_valid_i) && complete_list_i[scan_i[i].T_new] &&
                    !(scan_i[i].is_store && n_st >= store_cap)) begin
                    retire_mask_o[i] = 1'b1;
                    n_ret++;
                    if (scan_i[i].is_store) n_st++;
                    // Halt/illegal outranks a mispredict flagged on the same entry.
                    if (scan_i[i].ends_halt) begin
                        term_kind_o = TERM_HALT;
                        term_idx_o  = IW'(i);
                        scan_open   = 1'b0;
                    end else if (scan_i[i].ends_flush) begin
                        term_kind_o = TERM_MISPREDICT;
                        term_idx_o  = IW'(i);
                        scan_open   = 1'b0;
                    end
                end else begin
                    scan_open = 1'b0;
                end
            end
        end

        num_retiring_o       = CW'(n_ret);
        num_store_retiring_o = CW'(n_st);
    end

endmodule

// File: rtl/retire_stage.sv
// In-order retire stage: frees T_old tags, reads committed values, registers
// commit packets and owns the mispredict-flush pulse and sticky halt.
module retire_stage
    import retire_stage_pkg::*;
#(
    parameter int  RETIRE_WIDTH = N,
    parameter int  PHYS_REGS    = PHYS_REG_SZ_R10K,
    parameter int  STORE_PORTS  = 1,
    localparam int CW           = $clog2(RETIRE_WIDTH + 1),
    localparam int IW           = (RETIRE_WIDTH > 1) ? $clog2(RETIRE_WIDTH) : 1
) (
    input  logic                              clock,
    input  logic                              reset,
    input  ROB_PACKET    [RETIRE_WIDTH-1:0]   rob_entries,
    input  logic [CW-1:0]                     rob_valid,
    input  logic [PHYS_REGS-1:0]              complete_list,
    input  logic [CW-1:0]                     sq_store_credit,
    output logic [CW-1:0]                     num_retiring,
    output logic [CW-1:0]                     num_store_retiring,
    output PHYS_REG_IDX  [RETIRE_WIDTH-1:0]   phys_free,
    output logic [CW-1:0]                     phys_free_valid,
    output PHYS_REG_IDX  [RETIRE_WIDTH-1:0]   rf_read_idx,
    input  DATA          [RETIRE_WIDTH-1:0]   rf_read_data,
    output COMMIT_PACKET [RETIRE_WIDTH-1:0]   committed_insts,
    output logic                              flush,
    output ADDR                               flush_pc,
    output logic                              halted
);

    RETIRE_STATE                      state_q, state_d;
    ADDR                              flush_pc_q, flush_pc_d;
    COMMIT_PACKET [RETIRE_WIDTH-1:0]  commit_q, commit_d;
    SCAN_ENTRY    [RETIRE_WIDTH-1:0]  scan;
    logic [RETIRE_WIDTH-1:0]          retire_mask;
    TERM_KIND                         term_kind;
    logic [IW-1:0]                    term_idx;

    always_comb begin
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            scan[i].T_new      = rob_entries[i].T_new;
            scan[i].is_store   = rob_entries[i].is_store;
            scan[i].ends_halt  = rob_entries[i].halt | rob_entries[i].illegal;
            scan[i].ends_flush = rob_entries[i].mispredict;
        end
    end

    retire_select #(
        .RETIRE_WIDTH (RETIRE_WIDTH),
        .PHYS_REGS    (PHYS_REGS),
        .STORE_PORTS  (STORE_PORTS)
    ) u_select (
        .enable_i             (state_q == RUN),
        .scan_i               (scan),
        .rob_valid_i          (rob_valid),
        .complete_list_i      (complete_list),
        .sq_store_credit_i    (sq_store_credit),
        .retire_mask_o        (retire_mask),
        .num_retiring_o       (num_retiring),
        .num_store_retiring_o (num_store_retiring),
        .term_kind_o          (term_kind),
        .term_idx_o           (term_idx)
    );

    // Freed tags are packed toward slot 0; entries without a destination leave no hole.
    always_comb begin
        int slot;
        phys_free   = '0;
        rf_read_idx = '0;
        slot        = 0;
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            if (retire_mask[i]) begin
                rf_read_idx[i] = rob_entries[i].T_new;
                if (rob_entries[i].has_dest) begin
                    phys_free[IW'(slot)] = rob_entries[i].T_old;
                    slot++;
                end
            end
        end
        phys_free_valid = CW'(slot);
    end

    always_comb begin
        for (int i = 0; i < RETIRE_WIDTH; i++) begin
            commit_d[i] = '0;
            if (retire_mask[i]) begin
                commit_d[i].data    = rf_read_data[i];
                commit_d[i].reg_idx = rob_entries[i].arch_reg;
                commit_d[i].NPC     = rob_entries[i].NPC;
                commit_d[i].halt    = rob_entries[i].halt;
                commit_d[i].illegal = rob_entries[i].illegal;
                commit_d[i].valid   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        flush_pc_d = flush_pc_q;
        unique case (state_q)
            RUN: begin
                if (term_kind == TERM_HALT) begin
                    state_d = HALTED;
                end else if (term_kind == TERM_MISPREDICT) begin
                    state_d    = FLUSH;
                    flush_pc_d = rob_entries[term_idx].target_pc;
                end
            end
            FLUSH:   state_d = RUN;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= RUN;
            flush_pc_q <= '0;
            // NOTE: the commit bank is reset, not left undefined, because consumers trust its valid bits from the first cycle.
            commit_q   <= '0;
        end else begin
            state_q    <= state_d;
            flush_pc_q <= flush_pc_d;
            commit_q   <= commit_d;
        end
    end

    assign committed_insts = commit_q;
    assign flush           = (state_q == FLUSH);
    assign flush_pc        = flush_pc_q;
    assign halted          = (state_q == HALTED);

endmodule

// File: tb/tb_retire_stage.sv
// Self-checking bench for retire_stage: a retire-rule model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_retire_stage;
    import retire_stage_pkg::*;

    localparam int W = 4;

    logic                       clock;
    logic                       reset;
    ROB_PACKET    [W-1:0]       rob_entries;
    logic [2:0]                 rob_valid;
    logic [PHYS_REG_SZ_R10K-1:0] complete_list;
    logic [2:0]                 sq_store_credit;
    logic [2:0]                 num_retiring;
    logic [2:0]                 num_store_retiring;
    PHYS_REG_IDX  [W-1:0]       phys_free;
    logic [2:0]                 phys_free_valid;
    PHYS_REG_IDX  [W-1:0]       rf_read_idx;
    DATA          [W-1:0]       rf_read_data;
    COMMIT_PACKET [W-1:0]       committed_insts;
    logic                       flush;
    ADDR                        flush_pc;
    logic                       halted;

    retire_stage #(
        .RETIRE_WIDTH (W),
        .PHYS_REGS    (PHYS_REG_SZ_R10K),
        .STORE_PORTS  (2)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .rob_entries        (rob_entries),
        .rob_valid          (rob_valid),
        .complete_list      (complete_list),
        .sq_store_credit    (sq_store_credit),
        .num_retiring       (num_retiring),
        .num_store_retiring (num_store_retiring),
        .phys_free          (phys_free),
        .phys_free_valid    (phys_free_valid),
        .rf_read_idx        (rf_read_idx),
        .rf_read_data       (rf_read_data),
        .committed_insts    (committed_insts),
        .flush              (flush),
        .flush_pc           (flush_pc),
        .halted             (halted)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Regfile stand-in: value is a fixed tag ORed with the physical register number.
    always_comb begin
        for (int i = 0; i < W; i++) rf_read_data[i] = 32'hDA7A_0000 | 32'(rf_read_idx[i]);
    end

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;
    bit done     = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model state: what the registered outputs must show this cycle.
    bit                   m_halted = 1'b0;
    bit                   m_flush  = 1'b0;
    ADDR                  m_flush_pc = '0;
    COMMIT_PACKET [W-1:0] m_commit = '0;

    // Retire rules: walk the valid head oldest-first, stop on the first entry that cannot go.
    task automatic model_comb(output int nret, output int nst, output int end_kind, output ADDR end_pc);
        int cap;
        nret = 0; nst = 0; end_kind = 0; end_pc = '0;
        cap = (int'(sq_store_credit) < 2) ? int'(sq_store_credit) : 2;
        if (m_halted || m_flush) return;
        for (int i = 0; i < int'(rob_valid); i++) begin
            if (!complete_list[rob_entries[i].T_new]) break;
            if (rob_entries[i].is_store && nst == cap) break;
            nret++;
            if (rob_entries[i].is_store) nst++;
            if (rob_entries[i].halt || rob_entries[i].illegal) begin end_kind = 1; break; end
            if (rob_entries[i].mispredict) begin end_kind = 2; end_pc = rob_entries[i].target_pc; break; end
        end
    endtask

    initial begin : compare
        int nret, nst, end_kind;
        ADDR end_pc;
        PHYS_REG_IDX fq[$];
        wait (cmp_en);
        while (!done) begin
            @(negedge clock);
            if (done) break;
            model_comb(nret, nst, end_kind, end_pc);
            fq.delete();
            for (int i = 0; i < nret; i++)
                if (rob_entries[i].has_dest) fq.push_back(rob_entries[i].T_old);

            check("num_retiring", num_retiring, nret);
            check("num_store_retiring", num_store_retiring, nst);
            check("phys_free_valid", phys_free_valid, fq.size());
            for (int s = 0; s < W; s++) begin
                if (s < fq.size()) check($sformatf("phys_free[%0d]", s), phys_free[s], fq[s]);
                else if (nret == 0) check($sformatf("phys_free_idle[%0d]", s), phys_free[s], 0);
                check($sformatf("rf_read_idx[%0d]", s), rf_read_idx[s], (s < nret) ? rob_entries[s].T_new : 6'd0);
                check($sformatf("commit[%0d]", s), committed_insts[s], m_commit[s]);
            end
            check("flush", flush, m_flush);
            if (m_flush) check("flush_pc", flush_pc, m_flush_pc);
            check("halted", halted, m_halted);

            if (reset) begin
                m_halted = 1'b0;
                m_flush  = 1'b0;
                m_commit = '0;
            end else begin
                for (int i = 0; i < W; i++) begin
                    m_commit[i] = '0;
                    if (i < nret) begin
                        m_commit[i].data    = 32'hDA7A_0000 | 32'(rob_entries[i].T_new);
                        m_commit[i].reg_idx = rob_entries[i].arch_reg;
                        m_commit[i].NPC     = rob_entries[i].NPC;
                        m_commit[i].halt    = rob_entries[i].halt;
                        m_commit[i].illegal = rob_entries[i].illegal;
                        m_commit[i].valid   = 1'b1;
                    end
                end
                m_flush = (end_kind == 2);
                if (end_kind == 2) m_flush_pc = end_pc;
                m_halted = m_halted || (end_kind == 1);
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic load_normal(input int base);
        for (int i = 0; i < W; i++) begin
            rob_entries[i]          = '0;
            rob_entries[i].T_new    = PHYS_REG_IDX'(base + i);
            rob_entries[i].T_old    = PHYS_REG_IDX'(base + 20 + i);
            rob_entries[i].arch_reg = REG_IDX'(i + 1);
            rob_entries[i].has_dest = 1'b1;
            rob_entries[i].NPC      = ADDR'(32'h1000 + 4 * (base + i));
        end
    endtask

    initial begin : stimulus
        reset = 1'b1; rob_entries = '0; rob_valid = '0; complete_list = '1; sq_store_credit = '0;
        repeat (2) @(posedge clock);
        #1; reset = 1'b0; cmp_en = 1'b1;

        @(negedge clock);
        check("rst_flush", flush, 0);
        check("rst_halted", halted, 0);
        check("rst_flush_pc", flush_pc, 0);
        check("rst_commit_valid_any", |committed_insts, 0);

        // Full-width retire, all complete, no stores.
        cyc(); load_normal(10); rob_valid = 3'd4;
        @(negedge clock);
        check("t1_nret", num_retiring, 4);
        check("t1_pfv", phys_free_valid, 4);
        check("t1_pf0", phys_free[0], 30);
        check("t1_pf3", phys_free[3], 33);
        cyc(); rob_valid = '0;
        @(negedge clock);
        check("t1_c2_data", committed_insts[2].data, 32'hDA7A000C);
        check("t1_c3_valid", committed_insts[3].valid, 1);
        check("t1_c0_reg", committed_insts[0].reg_idx, 1);
        check("idle_nret", num_retiring, 0);

        // Incomplete entry 1 blocks everything younger.
        cyc(); load_normal(10); complete_list[11] = 1'b0; rob_valid = 3'd4;
        @(negedge clock);
        check("t2_nret", num_retiring, 1);
        cyc(); rob_valid = '0; complete_list = '1;
        @(negedge clock);
        check("t2_c0_valid", committed_insts[0].valid, 1);
        check("t2_c1_zero", committed_insts[1], 0);

        // Store port cap (2) below SQ credit (3).
        cyc(); load_normal(0); sq_store_credit = 3'd3; rob_valid = 3'd4;
        for (int i = 0; i < 3; i++) begin rob_entries[i].is_store = 1'b1; rob_entries[i].has_dest = 1'b0; end
        @(negedge clock);
        check("t3_nret", num_retiring, 2);
        check("t3_nst", num_store_retiring, 2);
        check("t3_pfv", phys_free_valid, 0);
        cyc(); sq_store_credit = 3'd0;
        @(negedge clock);
        check("t3_nocredit_nret", num_retiring, 0);
        cyc(); sq_store_credit = 3'd1;
        @(negedge clock);
        check("t3_nocredit_flush", flush, 0);
        check("t3_nocredit_halted", halted, 0);
        check("t3_credit1_nret", num_retiring, 1);

        // Mispredict at entry 1 closes the group and flushes for one cycle.
        cyc(); load_normal(20); sq_store_credit = '0; rob_valid = 3'd4;
        rob_entries[1].mispredict = 1'b1; rob_entries[1].target_pc = 32'h40;
        @(negedge clock);
        check("t4_nret", num_retiring, 2);
        cyc();
        @(negedge clock);
        check("t4_flush", flush, 1);
        check("t4_flush_pc", flush_pc, 32'h40);
        check("t4_flush_nret", num_retiring, 0);
        cyc(); load_normal(36);
        @(negedge clock);
        check("t4_after_flush", flush, 0);
        check("t4_after_nret", num_retiring, 4);

        // Entry without a destination frees nothing; freed tags compact.
        cyc(); load_normal(20); rob_entries[0].has_dest = 1'b0; rob_entries[1].T_old = 6'd17; rob_valid = 3'd2;
        @(negedge clock);
        check("t5_nret", num_retiring, 2);
        check("t5_pfv", phys_free_valid, 1);
        check("t5_pf0", phys_free[0], 17);

        // Mispredict in the last slot, then reset during the flush cycle.
        cyc(); load_normal(0); rob_valid = 3'd4; rob_entries[3].mispredict = 1'b1; rob_entries[3].target_pc = 32'h80;
        @(negedge clock);
        check("t6_nret", num_retiring, 4);
        cyc(); reset = 1'b1;
        @(negedge clock);
        check("t6_flush", flush, 1);
        check("t6_flush_pc", flush_pc, 32'h80);
        cyc(); reset = 1'b0; rob_valid = '0;
        @(negedge clock);
        check("t6_reset_flush", flush, 0);

        // Reset in the cycle a mispredict retires drops the pending flush.
        cyc(); load_normal(0); rob_valid = 3'd4; rob_entries[0].mispredict = 1'b1; reset = 1'b1;
        cyc(); reset = 1'b0; rob_valid = '0;
        @(negedge clock);
        check("t6b_dropped_flush", flush, 0);

        // Halt at the head: sticky until reset.
        cyc(); load_normal(30); rob_valid = 3'd4; rob_entries[0].halt = 1'b1;
        @(negedge clock);
        check("t7_nret", num_retiring, 1);
        cyc(); load_normal(30);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("t7_halted", halted, 1);
            check("t7_halted_nret", num_retiring, 0);
            cyc();
        end
        reset = 1'b1;
        @(negedge clock);
        check("t7_halted_in_reset", halted, 1);
        cyc(); reset = 1'b0;
        @(negedge clock);
        check("t7_cleared", halted, 0);
        check("t7_resume_nret", num_retiring, 4);

        // Illegal at entry 2 with a partial head.
        cyc(); load_normal(10); rob_valid = 3'd3; rob_entries[2].illegal = 1'b1;
        @(negedge clock);
        check("t8_nret", num_retiring, 3);
        cyc(); rob_valid = '0;
        @(negedge clock);
        check("t8_halted", halted, 1);
        check("t8_c2_illegal", committed_insts[2].illegal, 1);
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0; load_normal(0); rob_valid = 3'd2;
        @(negedge clock);
        check("t8_partial_nret", num_retiring, 2);

        cyc(); rob_valid = '0; done = 1'b1;
        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
